axilxbar_slvarb: RTL and testbench

//  Per-slave arbiter for the AXI-lite crossbar. Takes the decoded one-per-master

---
 rtl/axilxbar_slvarb.sv | 131 +++++++++++++
 tb/tb_axilxbar_slvarb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axilxbar_slvarb.sv
// Per-slave arbiter for the AXI-lite crossbar: grants one master at a time and
// holds it until its outstanding count drains. Optional macro: AXILXBAR_SLVARB_LINGER_EN.
module axilxbar_slvarb #(
    parameter int unsigned NM       = 4,
    parameter int unsigned LGMAXOUT = 5
`ifdef AXILXBAR_SLVARB_LINGER_EN
    ,
    parameter int unsigned LINGER   = 8
`endif
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [NM-1:0]                       i_request,
    output logic [NM-1:0]                       o_mstall,
    output logic [NM-1:0]                       o_grant,
    output logic [((NM > 1) ? $clog2(NM) : 1)-1:0] o_sindex,
    output logic                                o_svalid,
    input  logic                                i_sstall,
    input  logic                                i_sreturn,
    output logic                                o_busy
);
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [LGMAXOUT-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t              state;
    logic [LGMAXOUT-1:0] count;
    logic [LGMAXOUT-1:0] count_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       winner;
    logic                found;
    logic                full;
    logic                mreq;
    logic                others;
    logic                accept;
    logic                idle_hit;
    logic                release_ok;

    // Slave-side valid, master stalls, counter update and round-robin pick
    always_comb begin
        full      = (count == CNT_MAX);
        mreq      = i_request[o_sindex];
        others    = |(i_request & ~o_grant);
        o_svalid  = (state == S_ACTIVE) && mreq && !full;
        accept    = o_svalid && !i_sstall;
        o_mstall  = '1;
        if (state == S_ACTIVE)
            o_mstall[o_sindex] = !o_svalid || i_sstall;
        o_busy    = (state != S_IDLE) || (count != '0);

        count_nxt = count;
        if (accept && !i_sreturn)
            count_nxt = count + LGMAXOUT'(1);
        else if (i_sreturn && !accept && (count != '0))
            count_nxt = count - LGMAXOUT'(1);

        idle_hit = (count == '0) && !mreq && !accept && !others;

        winner = rr_ptr;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NM; k++) begin
            if (!found && i_request[IW'((32'(rr_ptr) + k) % NM)]) begin
                found  = 1'b1;
                winner = IW'((32'(rr_ptr) + k) % NM);
            end
        end
    end

`ifdef AXILXBAR_SLVARB_LINGER_EN
    localparam int unsigned LW = $clog2(LINGER + 1);
    logic [LW-1:0] linger_cnt;

    assign release_ok = idle_hit && (linger_cnt == LW'(LINGER - 1));

    // Consecutive quiet cycles while the grant is held
    always_ff @(posedge i_clk) begin
        if (i_reset)
            linger_cnt <= '0;
        else if ((state == S_ACTIVE) && idle_hit && !release_ok)
            linger_cnt <= linger_cnt + LW'(1);
        else
            linger_cnt <= '0;
    end
`else
    assign release_ok = idle_hit;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            o_grant  <= '0;
            o_sindex <= '0;
            rr_ptr   <= IW'(NM - 1);
            count    <= '0;
        end else begin
            count <= count_nxt;
            case (state)
                S_IDLE: begin
                    if (|i_request) begin
                        state    <= S_ACTIVE;
                        o_grant  <= NM'(1) << winner;
                        o_sindex <= winner;
                    end
                end
                S_ACTIVE: begin
                    if (others) begin
                        state  <= S_DRAIN;
                        rr_ptr <= o_sindex;
                    end else if (release_ok) begin
                        state   <= S_IDLE;
                        o_grant <= '0;
                        rr_ptr  <= o_sindex;
                    end
                end
                S_DRAIN: begin
                    // Drained master keeps lowest priority via rr_ptr
                    if (count_nxt == '0) begin
                        state   <= S_IDLE;
                        o_grant <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axilxbar_slvarb.sv
// Randomized bench for axilxbar_slvarb against a transaction-level model of the
// grant/drain/outstanding rules; directed prologue covers the documented scenarios.
module tb_axilxbar_slvarb;
    localparam int NM       = 4;
    localparam int LGMAXOUT = 2;
    localparam int MAXOUT   = (1 << LGMAXOUT) - 1;
`ifdef AXILXBAR_SLVARB_LINGER_EN
    localparam int HOLD = 8;
`else
    localparam int HOLD = 1;
`endif

    logic          i_clk;
    logic          i_reset;
    logic [NM-1:0] i_request;
    logic [NM-1:0] o_mstall;
    logic [NM-1:0] o_grant;
    logic [1:0]    o_sindex;
    logic          o_svalid;
    logic          i_sstall;
    logic          i_sreturn;
    logic          o_busy;

    axilxbar_slvarb #(.NM(NM), .LGMAXOUT(LGMAXOUT)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_request(i_request),
        .o_mstall(o_mstall), .o_grant(o_grant), .o_sindex(o_sindex),
        .o_svalid(o_svalid), .i_sstall(i_sstall), .i_sreturn(i_sreturn),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model: mode 0 idle, 1 owner holds grant, 2 owner draining
    int m_mode, m_owner, m_cnt, m_ptr, m_sidx, m_quiet;
    int n_cmp, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_svalid(input logic [NM-1:0] req);
        return (m_mode == 1) && req[m_owner] && (m_cnt < MAXOUT);
    endfunction

    task automatic model_update(input logic [NM-1:0] req, input logic st, input logic ret,
                                input logic rst);
        bit acc;
        int ncnt;
        if (rst) begin
            m_mode = 0; m_owner = -1; m_cnt = 0; m_ptr = NM - 1; m_sidx = 0; m_quiet = 0;
            return;
        end
        acc  = exp_svalid(req) && !st;
        ncnt = m_cnt;
        if (acc && !ret) ncnt = m_cnt + 1;
        else if (ret && !acc && m_cnt > 0) ncnt = m_cnt - 1;
        case (m_mode)
            0: if (req != 0) begin
                for (int k = 1; k <= NM; k++)
                    if (m_owner < 0 && req[(m_ptr + k) % NM]) m_owner = (m_ptr + k) % NM;
                m_mode = 1; m_sidx = m_owner; m_quiet = 0;
            end
            1: begin
                if ((req & ~(NM'(1) << m_owner)) != 0) begin
                    m_mode = 2; m_ptr = m_owner; m_quiet = 0;
                end else if (m_cnt == 0 && !req[m_owner] && !acc) begin
                    m_quiet++;
                    if (m_quiet >= HOLD) begin
                        m_mode = 0; m_ptr = m_owner; m_owner = -1; m_quiet = 0;
                    end
                end else begin
                    m_quiet = 0;
                end
            end
            default: if (ncnt == 0) begin
                m_mode = 0; m_owner = -1;
            end
        endcase
        m_cnt = ncnt;
    endtask

    // One clock: drive after negedge, compare mid-cycle, advance model at posedge
    task automatic step(input logic [NM-1:0] req, input logic st, input logic ret,
                        input logic rst, input bit chk);
        logic [NM-1:0] e_ms;
        bit e_sv;
        @(negedge i_clk);
        i_request = req; i_sstall = st; i_sreturn = ret; i_reset = rst;
        #1;
        if (chk) begin
            e_sv = exp_svalid(req);
            e_ms = '1;
            if (m_mode == 1) e_ms[m_owner] = !e_sv || st;
            check("svalid", 32'(o_svalid), 32'(e_sv));
            check("mstall", 32'(o_mstall), 32'(e_ms));
            check("grant",  32'(o_grant),  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("sindex", 32'(o_sindex), 32'(m_sidx));
            check("busy",   32'(o_busy),   32'((m_mode != 0) || (m_cnt != 0)));
        end
        @(posedge i_clk);
        model_update(req, st, ret, rst);
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    logic [NM-1:0] rq;

    initial begin
        n_cmp = 0; n_err = 0;
        m_mode = 0; m_owner = -1; m_cnt = 0; m_ptr = NM - 1; m_sidx = 0; m_quiet = 0;
        i_request = '0; i_sstall = 1'b0; i_sreturn = 1'b0; i_reset = 1'b1;

        // Reset values, then single requester 2
        do_reset();
        check("rst_grant",  32'(o_grant),  32'h0);
        check("rst_mstall", 32'(o_mstall), 32'hF);
        check("rst_busy",   32'(o_busy),   32'h0);
        step(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        check("t1_grant",  32'(o_grant),  32'h4);
        check("t1_sindex", 32'(o_sindex), 32'h2);
        check("t1_svalid", 32'(o_svalid), 32'h1);
        step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (HOLD + 2) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Two requesters from pointer 3: 0, then 1, then 0 again
        do_reset();
        repeat (10) step(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1);

        // Three outstanding on master 1, master 2 forces drain
        do_reset();
        repeat (4) step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) step(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);

        // Full counter at LGMAXOUT=2, return reopens, accept+return holds
        do_reset();
        repeat (5) step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset while draining with two outstanding
        do_reset();
        repeat (3) step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        check("t5_grant",  32'(o_grant),  32'h0);
        check("t5_svalid", 32'(o_svalid), 32'h0);
        check("t5_busy",   32'(o_busy),   32'h0);

        // Quiet gap shorter than the linger window, then a longer one
        do_reset();
        step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (10) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic with sticky requests
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0)
                for (int b = 0; b < NM; b++) rq[b] = ($urandom_range(2) == 0);
            step(rq, ($urandom_range(9) < 3), ($urandom_range(9) < 4),
                 ($urandom_range(499) == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
